// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 instruction codes, processor status codes and SEQ sequencer state encoding
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_PCUPD  = 3'd6;
    localparam logic [2:0] ST_HALT   = 3'd7;

endpackage

// File: rtl/seq_instr_class.sv
// seq_instr_class: combinational instruction classifier (validity, memory use, register writeback, memory write)
module seq_instr_class
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    output logic       valid,
    output logic       needs_mem,
    output logic       needs_wb,
    output logic       mem_we
);

    assign valid = (icode == I_OPQ) ? (ifun <= 4'd3) :
                   (icode == I_RRMOVQ || icode == I_JXX) ? (ifun <= 4'd6) :
                   (icode <= I_POPQ && ifun == 4'd0);

    assign needs_mem = icode == I_RMMOVQ || icode == I_MRMOVQ || icode == I_CALL ||
                       icode == I_RET || icode == I_PUSHQ || icode == I_POPQ;

    // Every register-writing instruction; rmmovq is the only memory instruction without one
    assign needs_wb = icode == I_RRMOVQ || icode == I_IRMOVQ || icode == I_OPQ || icode == I_MRMOVQ ||
                      icode == I_CALL || icode == I_RET || icode == I_PUSHQ || icode == I_POPQ;

    assign mem_we = icode == I_RMMOVQ || icode == I_CALL || icode == I_PUSHQ;

endmodule

// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl: multi-cycle Y86-64 SEQ stage sequencer; define PERF_CNT_EN to add cycle/retired counters
module seq_stage_ctrl
    import y86_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    input  logic       imem_error,
    input  logic       mem_ack,
    input  logic       dmem_error,
    output logic       fetch_en,
    output logic       decode_en,
    output logic       exec_en,
    output logic       wb_en,
    output logic       pc_en,
    output logic       cc_en,
    output logic       mem_req,
    output logic       mem_we,
    output logic [2:0] stat,
    output logic       busy
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
`endif
);

    logic [2:0] state, nxt, nxt_stat;
    logic [3:0] ic, cls_icode;
    logic [7:0] tcnt;
    logic       valid, needs_mem, needs_wb, cls_we;

    // Live code is classified during FETCH; afterwards the latched copy drives all decisions
    assign cls_icode = (state == ST_FETCH) ? icode : ic;

    seq_instr_class u_class (
        .icode     (cls_icode),
        .ifun      (ifun),
        .valid     (valid),
        .needs_mem (needs_mem),
        .needs_wb  (needs_wb),
        .mem_we    (cls_we)
    );

    // Next-state and status selection
    always_comb begin
        nxt = state;
        nxt_stat = stat;
        case (state)
            ST_IDLE:   nxt = start ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                if (imem_error) begin
                    nxt = ST_HALT;
                    nxt_stat = S_ADR;
                end else if (!valid) begin
                    nxt = ST_HALT;
                    nxt_stat = S_INS;
                end else if (cls_icode == I_HALT) begin
                    nxt = ST_HALT;
                    nxt_stat = S_HLT;
                end else begin
                    nxt = (cls_icode == I_NOP) ? ST_PCUPD : ST_DECODE;
                end
            end
            ST_DECODE: nxt = ST_EXEC;
            ST_EXEC:   nxt = needs_mem ? ST_MEM : needs_wb ? ST_WB : ST_PCUPD;
            ST_MEM: begin
                if (mem_ack) begin
                    nxt = dmem_error ? ST_HALT : needs_wb ? ST_WB : ST_PCUPD;
                    nxt_stat = dmem_error ? S_ADR : stat;
                end else if (tcnt == 8'(MEM_TIMEOUT - 1)) begin
                    nxt = ST_HALT;
                    nxt_stat = S_ADR;
                end
            end
            ST_WB:     nxt = ST_PCUPD;
            ST_PCUPD:  nxt = ST_FETCH;
            default:   nxt = ST_HALT;
        endcase
    end

    // State, status, memory wait counter and instruction latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            stat  <= S_AOK;
            tcnt  <= 8'd0;
            ic    <= 4'd0;
        end else begin
            state <= nxt;
            stat  <= nxt_stat;
            tcnt  <= (state == ST_MEM && nxt == ST_MEM) ? tcnt + 8'd1 : 8'd0;
            if (state == ST_FETCH) ic <= icode;
        end
    end

    assign fetch_en  = state == ST_FETCH;
    assign decode_en = state == ST_DECODE;
    assign exec_en   = state == ST_EXEC;
    assign wb_en     = state == ST_WB;
    assign pc_en     = state == ST_PCUPD;
    assign cc_en     = exec_en && ic == I_OPQ;
    assign mem_req   = state == ST_MEM;
    assign mem_we    = mem_req && cls_we;
    assign busy      = state != ST_IDLE && state != ST_HALT;

`ifdef PERF_CNT_EN
    // Busy-cycle and retired-instruction counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (busy) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (pc_en) retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// tb_seq_stage_ctrl: scoreboard bench for seq_stage_ctrl; per-instruction expected stage sequences from a rule-level model
module tb_seq_stage_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] icode = 4'd0;
    logic [3:0] ifun = 4'd0;
    logic       imem_error = 1'b0;
    logic       mem_ack = 1'b0;
    logic       dmem_error = 1'b0;
    logic       fetch_en, decode_en, exec_en, wb_en, pc_en, cc_en, mem_req, mem_we, busy;
    logic [2:0] stat;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    always #5 clk = ~clk;

    seq_stage_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .icode      (icode),
        .ifun       (ifun),
        .imem_error (imem_error),
        .mem_ack    (mem_ack),
        .dmem_error (dmem_error),
        .fetch_en   (fetch_en),
        .decode_en  (decode_en),
        .exec_en    (exec_en),
        .wb_en      (wb_en),
        .pc_en      (pc_en),
        .cc_en      (cc_en),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .stat       (stat),
        .busy       (busy)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
`endif
    );

    typedef struct packed {
        logic [3:0] ic;
        logic [3:0] fn;
        logic       ierr;
        logic [4:0] w;
        logic       derr;
    } ins_t;

    // bit order: fetch decode exec mem_req mem_we wb pc cc busy
    localparam logic [8:0] E_F  = 9'b100000001;
    localparam logic [8:0] E_D  = 9'b010000001;
    localparam logic [8:0] E_E  = 9'b001000001;
    localparam logic [8:0] E_M  = 9'b000100001;
    localparam logic [8:0] E_W  = 9'b000001001;
    localparam logic [8:0] E_P  = 9'b000000101;
    localparam logic [8:0] E_CC = 9'b000000010;
    localparam logic [8:0] E_WE = 9'b000010000;

    logic [11:0] exp_q[$];
    ins_t        prog[$];
    ins_t        cur = '0;
    bit          halt_issued = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk_ins(input int ic, input int fn, input int ierr = 0, input int w = 1, input int derr = 0);
        ins_t x;
        x.ic = 4'(ic);
        x.fn = 4'(fn);
        x.ierr = ierr != 0;
        x.w = 5'(w);
        x.derr = derr != 0;
        return x;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t x;
        int r;
        x = '0;
        r = $urandom_range(0, 31);
        x.ic = (r == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(1, 11));
        x.fn = (x.ic == 6) ? 4'($urandom_range(0, 3)) : (x.ic == 2 || x.ic == 7) ? 4'($urandom_range(0, 6)) : 4'd0;
        if ($urandom_range(0, 15) == 0) x.fn = 4'($urandom);
        x.ierr = $urandom_range(0, 31) == 0;
        r = $urandom_range(0, 9);
        x.w = r < 3 ? 5'd1 : r < 5 ? 5'd2 : r < 7 ? 5'd3 : r < 8 ? 5'd4 : r < 9 ? 5'd15 : 5'd0;
        x.derr = $urandom_range(0, 9) == 0;
        return x;
    endfunction

    task automatic push_halt(input logic [2:0] s);
        repeat (3) exp_q.push_back({9'b0, s});
        halt_issued = 1'b1;
    endtask

    // Expected per-cycle outputs for one instruction, from its FETCH cycle on (w==0: memory never acks)
    task automatic model(input ins_t x);
        logic ok;
        int n;
        exp_q.push_back({E_F, 3'd1});
        ok = (x.ic == 6) ? (x.fn <= 3) : (x.ic == 2 || x.ic == 7) ? (x.fn <= 6) : (x.ic <= 11 && x.fn == 0);
        if (x.ierr) push_halt(3'd3);
        else if (!ok) push_halt(3'd4);
        else if (x.ic == 0) push_halt(3'd2);
        else if (x.ic == 1) exp_q.push_back({E_P, 3'd1});
        else begin
            exp_q.push_back({E_D, 3'd1});
            exp_q.push_back({E_E | ((x.ic == 6) ? E_CC : 9'b0), 3'd1});
            if (x.ic inside {4, 5, 8, 9, 10, 11}) begin
                n = (x.w == 0) ? 15 : int'(x.w);
                repeat (n) exp_q.push_back({E_M | ((x.ic inside {4, 8, 10}) ? E_WE : 9'b0), 3'd1});
                if (x.w == 0 || x.derr) push_halt(3'd3);
                else begin
                    if (x.ic != 4) exp_q.push_back({E_W, 3'd1});
                    exp_q.push_back({E_P, 3'd1});
                end
            end else begin
                if (x.ic inside {2, 3, 6}) exp_q.push_back({E_W, 3'd1});
                exp_q.push_back({E_P, 3'd1});
            end
        end
    endtask

    // Driver: present the next program word in FETCH, noise otherwise; answer memory after the chosen wait
    initial begin
        int mcnt = 0;
        forever begin
            @(negedge clk);
            if (fetch_en === 1'b1) begin
                cur = (prog.size() != 0) ? prog.pop_front() : '0;
                icode = cur.ic;
                ifun = cur.fn;
                imem_error = cur.ierr;
                model(cur);
            end else begin
                icode = 4'($urandom);
                ifun = 4'($urandom);
                imem_error = 1'($urandom);
            end
            if (mem_req === 1'b1) begin
                mcnt++;
                mem_ack = (cur.w != 0) && (mcnt == int'(cur.w));
                dmem_error = mem_ack ? cur.derr : 1'($urandom);
            end else begin
                mcnt = 0;
                mem_ack = 1'($urandom);
                dmem_error = 1'($urandom);
            end
        end
    end

    // Monitor: compare every cycle for which an expectation is queued
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("stage_vec", {20'd0, fetch_en, decode_en, exec_en, mem_req, mem_we, wb_en, pc_en, cc_en, busy, stat},
                    {20'd0, e});
            end
        end
    end

    task automatic start_run();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        exp_q.delete();
        halt_issued = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) exp_q.push_back({9'b0, 3'd1});
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(halt_issued && exp_q.size() == 0) && n < 600) begin
            @(negedge clk);
            start = 1'($urandom);
            n++;
        end
        checks++;
        if (!(halt_issued && exp_q.size() == 0)) begin
            errors++;
            $display("FAIL run_done got pending=%0d halted=%0d want pending=0 halted=1", exp_q.size(), halt_issued);
        end
        prog.delete();
    endtask

    task automatic episode(input ins_t x);
        prog.push_back(x);
        start_run();
        wait_done();
    endtask

    initial begin
        int n;
        episode(mk_ins(6, 1));
        episode(mk_ins(5, 0, 0, 3));
        episode(mk_ins(4, 0, 0, 0));
        episode(mk_ins(6, 7));
        episode(mk_ins(12, 0));
        episode(mk_ins(0, 0));
        chk("halt_busy", {31'd0, busy}, 32'd0);
        chk("halt_stat", {29'd0, stat}, 32'd2);

        prog.push_back(mk_ins(10, 0, 0, 0));
        start_run();
        n = 0;
        while (mem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mem_reached", {31'd0, mem_req}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stat", {29'd0, stat}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fetch", {31'd0, fetch_en}, 32'd0);
        rst = 1'b0;
        prog.delete();

        prog.push_back(mk_ins(1, 0));
        prog.push_back(mk_ins(7, 3));
        prog.push_back(mk_ins(3, 0));
        prog.push_back(mk_ins(2, 6));
        prog.push_back(mk_ins(8, 0, 0, 15));
        prog.push_back(mk_ins(11, 0, 0, 1));
        prog.push_back(mk_ins(9, 0, 0, 2, 1));
        start_run();
        wait_done();
        episode(mk_ins(11, 0, 1));

`ifdef PERF_CNT_EN
        prog.push_back(mk_ins(1, 0));
        prog.push_back(mk_ins(7, 3));
        prog.push_back(mk_ins(3, 0));
        start_run();
        wait_done();
        chk("retired_cnt", retired_cnt, 32'd3);
        chk("cycle_cnt", cycle_cnt, 32'd12);
`endif

        repeat (8) begin
            repeat (8) prog.push_back(rnd_ins());
            start_run();
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
